gfp8_group_pack: RTL
====================

# gfp8_group_pack

Re-encodes a stream of wide GFP dot-product results into GFP8 groups. Each input is a 32-bit signed mantissa with an 8-bit signed exponent, where value = m·2^e. The block collects up to 32 results, derives one shared 5-bit biased exponent and quantizes each element to an 8-bit signed mantissa. It sits downstream of the group dot-product engines and feeds GFP8 groups back to result memory or the next layer.

## Interface
- GROUP_ID, 0, debug tag only
- GROUP_SIZE, 32, elements per group (only 32 supported; output width = GROUP_SIZE×8)
- i_clk  in  1  clock; one clock domain; reset is asynchronous and active-low
- i_reset_n  in  1  asynchronous active-low reset
- i_in_valid  in  1  input element valid
- o_in_ready  out  1  block accepts an element this cycle
- i_mantissa  in  32  signed result mantissa
- i_exponent  in  8  signed result exponent (unbiased, value = m·2^e)
- i_last  in  1  closes the group with this element
- o_out_valid  out  1  packed group valid
- i_out_ready  in  1  downstream accepts the group
- o_exp  out  5  shared exponent, bias 15; 0 means a zero group
- o_man  out  256  32×int8; element k is in o_man[8k+7:8k]
- o_sat  out  1  high exponent clip, or any element saturated
- o_underflow  out  1  low exponent clip (group not all-zero)

## Operation
- States: COLLECT → CONVERT → OUTPUT → COLLECT. Reset enters COLLECT with count=0, tmax cleared, nz=0.
- COLLECT: o_in_ready=1. Each accept (i_in_valid & o_in_ready):
  - stores (m,e) at slot count and increments count.
  - For m≠0, t = e + msb(|m|), where |m| is 33-bit and msb ∈ 0..31. Updates tmax = max(tmax,t) as 10-bit signed and sets nz.
  - If count==31 or i_last, the next state is CONVERT. Unfilled slots are forced to m=0.
- Shared exponent: E = tmax + 9. If nz=0, E=0. If E>31, E=31 and sat is set. If E<1, E=1 and underflow is set. Es = E−15.
- CONVERT: one element per cycle, j=0..31, via gfp8_elem_quant. Writes byte j of the o_man register.
  - s = Es − e_j (11-bit signed). m=0 gives 0.
  - s<0: magnitude shifted left by −s.
  - s>0: magnitude shifted right by s; s≥34 gives 0.
  - Rounding is set by the macro. The magnitude saturates to 127 and sets sat; the sign is reapplied. −128 is never produced.
- OUTPUT: o_out_valid=1. o_exp, o_man and the flags are held stable until i_out_ready. On handshake, the next state is COLLECT and count, tmax, nz and the flags are cleared.
- i_in_valid is ignored outside COLLECT. i_out_ready is ignored outside OUTPUT.

## Timing
- Reset values: o_out_valid=0, o_exp=0, o_man=0, o_sat=0, o_underflow=0, o_in_ready=1 (decoded from state).
- If the closing element is accepted at edge T: CONVERT runs on edges T+1..T+32, and o_out_valid rises after edge T+32.
- Throughput is ≥ (elements + 33) cycles per group. There is no overlap between collect and output.
- Reset mid-CONVERT or mid-OUTPUT aborts the group and returns all outputs to reset values.

## Configuration
- GFP8_PACK_ROUND_EN defined: right shifts round to nearest with ties away from zero (add 2^(s−1) to the magnitude before shifting).
- Not defined: right shifts truncate the magnitude (round toward zero).
- Left shifts and saturation are identical in both builds.

## Structure
- gfp8_pkg holds:
  - constants GFP_GROUP_SIZE=32, GFP_INT_SIZE=8, GFP_BIAS=15, GFP_EXP_W=5
  - the state enum
  - a packed gfp8_group_t {exp, man}
- Sub-module gfp8_elem_quant: combinational; (m, e, Es) → (q[7:0], sat).

## Test plan
- 32×(m=1, e=0) → o_exp=9, every byte 0x40, no flags.
- Element 0 = (1000, 0), element 1 = (−5, 0), i_last on element 1 → o_exp=18, byte0=0x7D.
  - Byte1=0xFF with ROUND_EN, 0x00 without; other bytes 0.
- 32 zero elements → o_exp=0, o_man=0, o_sat=o_underflow=0.
- Element 0 = (2^30, 100), rest zero → o_exp=31, byte0=0x7F, o_sat=1.
- Element 0 = (1, −40), i_last → o_exp=1, o_man=0, o_underflow=1.
- Hold i_out_ready=0 for 5 cycles in OUTPUT → outputs stable and o_in_ready=0.
  - Then assert reset during CONVERT of the next group → all outputs return to reset values and o_in_ready=1.

Source files
------------

// File: rtl/gfp8_pkg.sv
// gfp8_pkg: shared definitions for the GFP8 group packer.
//   - Group geometry constants (elements per group, bits per element, bias).
//   - FSM state encoding for gfp8_group_pack.
//   - gfp8_group_t: packed {exp, man} view of one finished group.
//   - msb_idx(): index of the highest set bit of a 32-bit magnitude.
package gfp8_pkg;

  localparam int GFP_GROUP_SIZE = 32;
  localparam int GFP_INT_SIZE   = 8;
  localparam int GFP_BIAS       = 15;
  localparam int GFP_EXP_W      = 5;
  localparam int GFP_MAN_W      = GFP_GROUP_SIZE * GFP_INT_SIZE;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_CONVERT = 2'd1,
    ST_OUTPUT  = 2'd2
  } gfp8_state_e;

  typedef struct packed {
    logic [GFP_EXP_W-1:0] exp;
    logic [GFP_MAN_W-1:0] man;
  } gfp8_group_t;

  // Highest set bit of a magnitude; returns 0 for a zero input (callers
  // only use it for nonzero mantissas).
  function automatic logic [4:0] msb_idx(input logic [31:0] mag);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gfp8_group_pack_if.sv
// gfp8_group_pack_if: element input stream and packed-group output stream
// of gfp8_group_pack.
//   i_in_valid/o_in_ready, i_mantissa[31:0], i_exponent[7:0], i_last
//   o_out_valid/i_out_ready, o_exp[4:0], o_man[255:0], o_sat, o_underflow
// Modports: master = upstream/downstream environment, slave = the packer.
interface gfp8_group_pack_if;
  import gfp8_pkg::*;

  logic                        i_in_valid;
  logic                        o_in_ready;
  logic signed [31:0]          i_mantissa;
  logic signed [7:0]           i_exponent;
  logic                        i_last;
  logic                        o_out_valid;
  logic                        i_out_ready;
  logic [GFP_EXP_W-1:0]        o_exp;
  logic [GFP_MAN_W-1:0]        o_man;
  logic                        o_sat;
  logic                        o_underflow;

  modport master (
    output i_in_valid, i_mantissa, i_exponent, i_last, i_out_ready,
    input  o_in_ready, o_out_valid, o_exp, o_man, o_sat, o_underflow
  );

  modport slave (
    input  i_in_valid, i_mantissa, i_exponent, i_last, i_out_ready,
    output o_in_ready, o_out_valid, o_exp, o_man, o_sat, o_underflow
  );

endinterface

// File: rtl/gfp8_elem_quant.sv
// gfp8_elem_quant: combinational quantizer of one (m, e) element against
// the group's unbiased shared exponent es.
//   m[31:0]  signed mantissa      e[7:0]  signed exponent
//   es[5:0]  signed shared exponent (E - bias)
//   q[7:0]   signed int8 result (never -128)
//   sat      magnitude clipped to 127
// Build option: GFP8_PACK_ROUND_EN selects round-half-away-from-zero on
// right shifts; otherwise right shifts truncate toward zero.
module gfp8_elem_quant
  import gfp8_pkg::*;
(
  input  logic signed [31:0] m,
  input  logic signed [7:0]  e,
  input  logic signed [5:0]  es,
  output logic [7:0]         q,
  output logic               sat
);

  logic [31:0]        mag;
  logic signed [10:0] s;
  logic [10:0]        lsh;
  logic [39:0]        lwide;
  logic [33:0]        rsum;
  logic [33:0]        rwide;
  logic [6:0]         mag_q;

  // |m| fits 32 bits unsigned, including m = -2^31.
  assign mag = m[31] ? (32'd0 - m) : m;
  assign s   = {{5{es[5]}}, es} - {{3{e[7]}}, e};

  always_comb begin
    mag_q = '0;
    sat   = 1'b0;
    lsh   = '0;
    lwide = '0;
    rsum  = '0;
    rwide = '0;
    if (mag != '0) begin
      if (s[10]) begin
        // Left shift: any nonzero magnitude shifted by 8+ exceeds 127.
        lsh = 11'(-s);
        if (lsh >= 11'd8) begin
          sat = 1'b1;
        end else begin
          lwide = {8'd0, mag} << lsh[2:0];
          if (lwide > 40'd127) sat = 1'b1;
          else                 mag_q = lwide[6:0];
        end
      end else if (s < 11'sd34) begin
        rsum = {2'b00, mag};
`ifdef GFP8_PACK_ROUND_EN
        if (s != 11'sd0) rsum = rsum + (34'd1 << (s[5:0] - 6'd1));
`endif
        rwide = rsum >> s[5:0];
        if (rwide > 34'd127) sat = 1'b1;
        else                 mag_q = rwide[6:0];
      end
    end
    if (sat) mag_q = 7'd127;
  end

  assign q = m[31] ? (8'd0 - {1'b0, mag_q}) : {1'b0, mag_q};

endmodule

// File: rtl/gfp8_group_pack.sv
// gfp8_group_pack: collects up to 32 (mantissa, exponent) results, derives
// one shared 5-bit exponent (bias 15) and quantizes each element to int8.
//   i_clk, i_reset_n (async active-low)
//   bus (gfp8_group_pack_if.slave): element input stream, packed output
//   group {o_exp, o_man} with o_sat / o_underflow flags.
// Flow: COLLECT (accept elements) -> CONVERT (32 cycles, one byte each)
// -> OUTPUT (hold until i_out_ready) -> COLLECT.
// Build option: GFP8_PACK_ROUND_EN (rounding in gfp8_elem_quant).
module gfp8_group_pack
  import gfp8_pkg::*;
#(
  parameter int GROUP_ID   = 0,
  parameter int GROUP_SIZE = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  gfp8_group_pack_if.slave  bus
);

  if (GROUP_SIZE != GFP_GROUP_SIZE) begin : g_bad_size
    $error("gfp8_group_pack %0d: only GROUP_SIZE=32 is supported", GROUP_ID);
  end

  gfp8_state_e        state_reg, state_next;
  logic [5:0]         count_reg;
  logic signed [9:0]  tmax_reg;
  logic               nz_reg;
  logic [4:0]         j_reg;
  logic [4:0]         exp_reg;
  logic               sat_reg;
  logic               uf_reg;
  logic [7:0]         man_reg [GROUP_SIZE];
  logic [GFP_MAN_W-1:0] man_flat;

  // Element storage: written on accept, read one slot per CONVERT cycle.
  logic signed [31:0] mem_m [GROUP_SIZE];
  logic signed [7:0]  mem_e [GROUP_SIZE];

  logic               in_ready;
  logic               out_valid;
  logic               accept;
  logic               close_grp;
  logic               out_hs;

  logic [31:0]        mag_in;
  logic signed [9:0]  t_in;
  logic               m_nz;

  logic signed [9:0]  e_full;
  logic [4:0]         exp_calc;
  logic               exp_sat;
  logic               exp_uf;
  logic signed [5:0]  es;

  logic signed [31:0] m_sel;
  logic signed [7:0]  e_sel;
  logic [7:0]         q;
  logic               q_sat;

  gfp8_group_t        grp;

  assign accept    = bus.i_in_valid & in_ready;
  assign close_grp = accept & ((count_reg == 6'd31) | bus.i_last);
  assign out_hs    = out_valid & bus.i_out_ready;

  // Top bit position of the incoming element: t = e + msb(|m|).
  assign mag_in = bus.i_mantissa[31] ? (32'd0 - bus.i_mantissa) : bus.i_mantissa;
  assign m_nz   = (bus.i_mantissa != 32'sd0);
  assign t_in   = {{2{bus.i_exponent[7]}}, bus.i_exponent} + {5'd0, msb_idx(mag_in)};

  // Shared exponent with clipping; a group of zeros encodes as E = 0.
  assign e_full = tmax_reg + 10'sd9;
  always_comb begin
    exp_calc = '0;
    exp_sat  = 1'b0;
    exp_uf   = 1'b0;
    if (nz_reg) begin
      if (e_full > 10'sd31) begin
        exp_calc = 5'd31;
        exp_sat  = 1'b1;
      end else if (e_full < 10'sd1) begin
        exp_calc = 5'd1;
        exp_uf   = 1'b1;
      end else begin
        exp_calc = e_full[4:0];
      end
    end
  end
  assign es = 6'({1'b0, exp_calc}) - 6'd15;

  // Slots past the last accepted element quantize as zero.
  assign m_sel = ({1'b0, j_reg} < count_reg) ? mem_m[j_reg] : 32'sd0;
  assign e_sel = ({1'b0, j_reg} < count_reg) ? mem_e[j_reg] : 8'sd0;

  gfp8_elem_quant u_quant (
    .m   (m_sel),
    .e   (e_sel),
    .es  (es),
    .q   (q),
    .sat (q_sat)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_reg <= ST_COLLECT;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_COLLECT: if (close_grp)       state_next = ST_CONVERT;
      ST_CONVERT: if (j_reg == 5'd31)  state_next = ST_OUTPUT;
      ST_OUTPUT:  if (bus.i_out_ready) state_next = ST_COLLECT;
      default:                         state_next = ST_COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == ST_COLLECT);
    out_valid = (state_reg == ST_OUTPUT);
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge i_clk) begin
    if (accept) begin
      mem_m[count_reg[4:0]] <= bus.i_mantissa;
      mem_e[count_reg[4:0]] <= bus.i_exponent;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_reg <= '0;
      tmax_reg  <= '0;
      nz_reg    <= 1'b0;
    end else if (out_hs) begin
      count_reg <= '0;
      tmax_reg  <= '0;
      nz_reg    <= 1'b0;
    end else if (accept) begin
      count_reg <= count_reg + 6'd1;
      if (m_nz) begin
        // The first nonzero element seeds tmax so negative t values survive.
        if (!nz_reg || (t_in > tmax_reg)) tmax_reg <= t_in;
        nz_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      j_reg   <= '0;
      exp_reg <= '0;
      sat_reg <= 1'b0;
      uf_reg  <= 1'b0;
    end else if (state_reg == ST_CONVERT) begin
      j_reg   <= j_reg + 5'd1;
      exp_reg <= exp_calc;
      sat_reg <= sat_reg | exp_sat | q_sat;
      uf_reg  <= uf_reg | exp_uf;
    end else if (out_hs) begin
      j_reg   <= '0;
      sat_reg <= 1'b0;
      uf_reg  <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < GROUP_SIZE; gi++) begin : g_byte
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        man_reg[gi] <= '0;
      end else if ((state_reg == ST_CONVERT) && (j_reg == 5'(gi))) begin
        man_reg[gi] <= q;
      end
    end
    assign man_flat[8*gi +: 8] = man_reg[gi];
  end

  assign grp = '{exp: exp_reg, man: man_flat};

  assign bus.o_in_ready  = in_ready;
  assign bus.o_out_valid = out_valid;
  assign bus.o_exp       = grp.exp;
  assign bus.o_man       = grp.man;
  assign bus.o_sat       = sat_reg;
  assign bus.o_underflow = uf_reg;

endmodule
